ysyx_25020042_mem_arb: RTL and testbench
========================================

YSYX_25020042_MEM_ARB -- requirements
Module: ysyx_25020042_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the width of every address port.
REQ-002 SHALL have parameter MEM_BASE, default 32'h80000000, the byte address of memory word 0.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, the number of 32-bit words in memory.
REQ-004 SHALL have parameter MEM_LAT, default 1, legal range 1..15, the number of cycles from mem_addr valid to mem_data sampled.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ifu_req_valid  input  1  instruction fetch request.
REQ-008 ifu_req_ready  output  1  fetch request accepted this cycle.
REQ-009 ifu_req_addr  input  ADDR_WIDTH  fetch byte address (pc).
REQ-010 ifu_rsp_valid  output  1  response for the fetch port.
REQ-011 ifu_rsp_ready  input  1  fetch port takes the response.
REQ-012 lsu_req_valid / lsu_req_ready / lsu_req_addr / lsu_rsp_valid / lsu_rsp_ready: same directions, widths and meanings as REQ-007..011, for the load port.
REQ-013 rsp_data  output  32  read word, shared by both ports; meaningful only while a rsp_valid is high.
REQ-014 rsp_err  output  1  response error flag; qualified the same way as rsp_data.
REQ-015 mem_addr  output  ADDR_WIDTH  byte address to the combinational read memory.
REQ-016 mem_data  input  32  word returned by the memory for mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP; only one transaction in flight.
REQ-018 IDLE, single valid requester: that requester's req_ready SHALL be 1 and the other port's req_ready 0.
REQ-019 IDLE, both valid: grant SHALL go to the port not served by the last completed transaction (round-robin); after reset IFU is preferred.
REQ-020 Outside IDLE, both req_ready outputs SHALL be 0.
REQ-021 On valid&&ready in cycle T, SHALL latch the address and the owner; the grant is combinational, so accept is in the same cycle.
REQ-022 A request SHALL be flagged as an error when addr[1:0]!=0 or addr is outside [MEM_BASE, MEM_BASE+4*MEM_DEPTH).
REQ-023 Error request: SHALL go IDLE->RESP at T+1 with rsp_err=1 and rsp_data=0; no WAIT cycles are spent.
REQ-024 Legal request: SHALL go to WAIT for exactly MEM_LAT cycles (counter loaded with MEM_LAT-1) and drive mem_addr from the latched address.
REQ-025 SHALL capture mem_data in the last WAIT cycle, then enter RESP; the owner's rsp_valid first rises at T+MEM_LAT+1.
REQ-026 RESP: only the owner's rsp_valid SHALL be 1; rsp_data and rsp_err SHALL stay stable until rsp_ready.
REQ-027 On rsp_valid&&rsp_ready, SHALL return to IDLE, update the round-robin pointer, and not accept a new request in that same cycle.
REQ-028 A request from the non-owner port SHALL stay pending without being dropped; requesters hold addr stable while valid.
REQ-029 mem_addr SHALL equal the latched address register at all times; it is 0 after reset.
REQ-030 The address-to-word index SHALL be computed as (addr - MEM_BASE) >> 2 in ADDR_WIDTH bits; in-range checking uses this value, so there is no wrap-around aliasing.

Reset
REQ-031 When rst=1 at a clock edge: state=IDLE, rsp_valid both 0, rsp_data=0, rsp_err=0, mem_addr=0, WAIT counter=0, round-robin preference=IFU.
REQ-032 Reset asserted mid-WAIT or mid-RESP SHALL abort the transaction silently; no response for it is ever issued.
REQ-033 While rst=1, both req_ready outputs SHALL be 0.

Structure
REQ-034 Shared package ysyx_25020042_pkg SHALL hold the FSM state enum and the default MEM_BASE/MEM_DEPTH constants.
REQ-035 The 2-way round-robin grant SHALL be the sub-module ysyx_25020042_rr_arb2 (inputs: two valids and a last-served bit; output: a one-hot grant).

Verification
REQ-036 IFU alone, addr 0x80000000, MEM_LAT=1, mem word 0x00500093, rsp_ready=1 -> ifu_rsp_valid high exactly 2 cycles after accept, rsp_data=0x00500093, rsp_err=0.
REQ-037 IFU and LSU valid together in the first cycle after reset -> IFU granted first, LSU granted next; then a repeat of the simultaneous request -> order alternates.
REQ-038 LSU addr 0x80000002, then addr 0x80001000 -> each gives lsu_rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0.
REQ-039 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable throughout; both req_ready stay 0; IDLE is reached the cycle after rsp_ready=1.
REQ-040 MEM_LAT=3: accept at T -> mem_addr valid T+1..T+3, rsp_valid at T+4; asserting rst at T+2 -> no rsp_valid ever for that request, and a new request is accepted in the first cycle after rst falls.

Source files
------------

// File: rtl/ysyx_25020042_pkg.sv
// Shared types and default memory geometry for the ysyx_25020042 memory arbiter.
package ysyx_25020042_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    localparam logic [31:0] MEM_BASE_DEFAULT  = 32'h8000_0000;
    localparam int unsigned MEM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/ysyx_25020042_rr_arb2.sv
// Two-way round-robin grant: on a tie the port that was not served last wins.
module ysyx_25020042_rr_arb2 (
    input  logic       i_valid_0,
    input  logic       i_valid_1,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // i_last = 1 means port 1 completed the most recent transaction
    always_comb begin
        o_grant[0] = i_valid_0 && (!i_valid_1 || i_last);
        o_grant[1] = i_valid_1 && (!i_valid_0 || !i_last);
    end

endmodule

// File: rtl/ysyx_25020042_mem_arb.sv
// Single-outstanding arbiter sharing one fixed-latency read memory between
// the instruction-fetch and load ports.
module ysyx_25020042_mem_arb
    import ysyx_25020042_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(MEM_BASE_DEFAULT),
    parameter int unsigned           MEM_DEPTH  = MEM_DEPTH_DEFAULT,
    parameter int unsigned           MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data
);

    localparam logic [ADDR_WIDTH-1:0] LP_DEPTH    = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0]            LP_CNT_INIT = 4'(MEM_LAT - 1);

    arb_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_owner;
    logic                  r_last;
    logic [3:0]            r_cnt;
    logic [31:0]           r_data;
    logic                  r_err;

    logic [1:0]            w_grant;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_sel_lsu;
    logic                  w_req_err;
    logic                  w_rsp_fire;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [ADDR_WIDTH-1:0] w_index;

    ysyx_25020042_rr_arb2 u_rr_arb2 (
        .i_valid_0 (ifu_req_valid),
        .i_valid_1 (lsu_req_valid),
        .i_last    (r_last),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_idle        = (r_state == StIdle) && !rst;
        ifu_req_ready = w_idle && w_grant[0];
        lsu_req_ready = w_idle && w_grant[1];
        w_accept      = ifu_req_ready || lsu_req_ready;
        w_sel_lsu     = w_grant[1];
        w_req_addr    = w_sel_lsu ? lsu_req_addr : ifu_req_addr;
        // Below-base addresses wrap to a huge index and fail the range test
        w_index       = (w_req_addr - MEM_BASE) >> 2;
        w_req_err     = (w_req_addr[1:0] != 2'b00) || (w_index >= LP_DEPTH);
        ifu_rsp_valid = (r_state == StResp) && !r_owner;
        lsu_rsp_valid = (r_state == StResp) && r_owner;
        w_rsp_fire    = (ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready);
    end

    assign mem_addr = r_addr;
    assign rsp_data = r_data;
    assign rsp_err  = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_addr  <= w_req_addr;
                        r_owner <= w_sel_lsu;
                        if (w_req_err) begin
                            r_state <= StResp;
                            r_err   <= 1'b1;
                            r_data  <= '0;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= LP_CNT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_data  <= mem_data;
                        r_err   <= 1'b0;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    if (w_rsp_fire) begin
                        r_state <= StIdle;
                        r_last  <= r_owner;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020042_mem_arb.sv
// Bench for ysyx_25020042_mem_arb: transaction-level model checked every cycle
// on a MEM_LAT=1 instance, plus directed checks on a MEM_LAT=3 instance.
module tb_ysyx_25020042_mem_arb;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 1;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ifu_v, lsu_v, ifu_rr, lsu_rr;
    logic [31:0] ifu_a, lsu_a;
    logic        ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, rsp_err;
    logic [31:0] rsp_data, mem_addr, mem_data;

    logic        rst3, ifu_v3, lsu_v3, one3;
    logic [31:0] ifu_a3, lsu_a3;
    logic        ifu_rdy3, lsu_rdy3, ifu_rv3, lsu_rv3, err3;
    logic [31:0] data3, maddr3, mdata3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Memory image: word 0 is a real instruction, others a simple ramp
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        if (idx >= 32'(DEPTH)) return 32'hBAD0_BAD0;
        if (idx == 32'd0) return 32'h0050_0093;
        return 32'h1000_0000 + idx * 32'h0001_0003;
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        longint unsigned v, lo, hi;
        v  = 64'(a);
        lo = 64'(BASE);
        hi = lo + 64'(4 * DEPTH);
        return (v % 4 != 0) || (v < lo) || (v >= hi);
    endfunction

    assign mem_data = mem_word(mem_addr);
    assign mdata3   = mem_word(maddr3);
    assign one3     = 1'b1;

    ysyx_25020042_mem_arb #(.MEM_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_v),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_a),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rr),
        .lsu_req_valid (lsu_v),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_a),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rr),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data)
    );

    ysyx_25020042_mem_arb #(.MEM_LAT(3)) dut3 (
        .clk           (clk),
        .rst           (rst3),
        .ifu_req_valid (ifu_v3),
        .ifu_req_ready (ifu_rdy3),
        .ifu_req_addr  (ifu_a3),
        .ifu_rsp_valid (ifu_rv3),
        .ifu_rsp_ready (one3),
        .lsu_req_valid (lsu_v3),
        .lsu_req_ready (lsu_rdy3),
        .lsu_req_addr  (lsu_a3),
        .lsu_rsp_valid (lsu_rv3),
        .lsu_rsp_ready (one3),
        .rsp_data      (data3),
        .rsp_err       (err3),
        .mem_addr      (maddr3),
        .mem_data      (mdata3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Transaction model: one job in flight, response due at a computed cycle
    bit          m_on = 0;
    bit          m_busy, m_owner_lsu, m_last_lsu, m_err;
    logic [31:0] m_addr, m_data;
    int          m_rsp_at;

    initial begin : model
        bit gi, gl;
        m_busy = 0; m_owner_lsu = 0; m_last_lsu = 1; m_err = 0;
        m_addr = '0; m_data = '0; m_rsp_at = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_on = 1; m_busy = 0; m_addr = '0; m_last_lsu = 1;
            end else if (!m_busy) begin
                gi = ifu_v && (!lsu_v || m_last_lsu);
                gl = lsu_v && !gi;
                if (gi || gl) begin
                    m_busy      = 1;
                    m_owner_lsu = gl;
                    m_addr      = gl ? lsu_a : ifu_a;
                    m_err       = is_bad(m_addr);
                    m_data      = m_err ? 32'h0 : mem_word(m_addr);
                    m_rsp_at    = cyc + (m_err ? 1 : LAT + 1);
                end
            end else if (cyc >= m_rsp_at && (m_owner_lsu ? lsu_rr : ifu_rr)) begin
                m_busy     = 0;
                m_last_lsu = m_owner_lsu;
            end
            cyc++;
        end
    end

    initial begin : compare
        bit gi, gl, vi, vl;
        forever begin
            @(negedge clk);
            if (m_on) begin
                gi = !rst && !m_busy && ifu_v && (!lsu_v || m_last_lsu);
                gl = !rst && !m_busy && lsu_v && !(ifu_v && m_last_lsu);
                vi = m_busy && (cyc >= m_rsp_at) && !m_owner_lsu;
                vl = m_busy && (cyc >= m_rsp_at) && m_owner_lsu;
                check("m_ifu_req_ready", ifu_req_ready, gi);
                check("m_lsu_req_ready", lsu_req_ready, gl);
                check("m_ifu_rsp_valid", ifu_rsp_valid, vi);
                check("m_lsu_rsp_valid", lsu_rsp_valid, vl);
                check("m_mem_addr", mem_addr, m_addr);
                if (vi || vl) begin
                    check("m_rsp_data", rsp_data, m_data);
                    check("m_rsp_err", rsp_err, m_err);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit lsu, output int at);
        at = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lsu ? lsu_req_ready : ifu_req_ready) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("wait_ready_timeout", lsu ? lsu_req_ready : ifu_req_ready, 1);
    endtask

    task automatic wait_rsp(input bit lsu, output int at);
        at = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lsu ? lsu_rsp_valid : ifu_rsp_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("wait_rsp_timeout", lsu ? lsu_rsp_valid : ifu_rsp_valid, 1);
    endtask

    logic [31:0] c_addr [4] = '{32'h8000_0002, 32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0FFC};
    logic [31:0] c_err  [4] = '{32'd1, 32'd1, 32'd1, 32'd0};
    logic [31:0] c_lat  [4] = '{32'd1, 32'd1, 32'd1, 32'd2};
    logic [31:0] c_data [4] = '{32'h0, 32'h0, 32'h0, 32'h13FF_0BFD};

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ta, tb_, tr, t2;
        rst = 1; ifu_v = 0; lsu_v = 0; ifu_a = '0; lsu_a = '0; ifu_rr = 1; lsu_rr = 1;
        rst3 = 1; ifu_v3 = 0; lsu_v3 = 0; ifu_a3 = '0; lsu_a3 = '0;
        step;
        ifu_v = 1; ifu_a = BASE;
        step;
        @(negedge clk);
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);

        // Single IFU fetch of word 0
        step; rst = 0;
        @(negedge clk);
        check("a_accept", ifu_req_ready, 1);
        check("a_lsu_ready", lsu_req_ready, 0);
        ta = cyc;
        step; ifu_v = 0;
        wait_rsp(0, tr);
        check("a_latency", tr - ta, 2);
        check("a_data", rsp_data, 32'h0050_0093);
        check("a_err", rsp_err, 0);
        step;

        // Tie right after reset: IFU first, then LSU
        rst = 1; step; rst = 0;
        ifu_v = 1; lsu_v = 1; ifu_a = BASE + 4; lsu_a = BASE + 8;
        @(negedge clk);
        check("b_tie1_ifu", ifu_req_ready, 1);
        check("b_tie1_lsu", lsu_req_ready, 0);
        ta = cyc;
        step; ifu_v = 0;
        wait_ready(1, tb_);
        check("b_lsu_gap", tb_ - ta, 3);
        step; lsu_v = 0;
        wait_rsp(1, tr);
        check("b_lsu_data", rsp_data, 32'h1002_0006);
        step;
        ifu_v = 1; lsu_v = 1;
        @(negedge clk);
        check("b_tie2_ifu", ifu_req_ready, 1);
        check("b_tie2_lsu", lsu_req_ready, 0);
        step; ifu_v = 0;
        wait_ready(1, tb_);
        step; lsu_v = 0;
        wait_rsp(1, tr);
        step;
        ifu_v = 1;
        wait_ready(0, ta);
        step; ifu_v = 0;
        wait_rsp(0, tr);
        step;
        ifu_v = 1; lsu_v = 1;
        @(negedge clk);
        check("b_tie3_lsu", lsu_req_ready, 1);
        check("b_tie3_ifu", ifu_req_ready, 0);
        step; lsu_v = 0;
        wait_ready(0, ta);
        step; ifu_v = 0;
        wait_rsp(0, tr);
        step;

        // Misaligned, range-boundary and last-word LSU accesses
        for (int k = 0; k < 4; k++) begin
            lsu_v = 1; lsu_a = c_addr[k];
            wait_ready(1, ta);
            step; lsu_v = 0;
            wait_rsp(1, tr);
            check("c_latency", tr - ta, c_lat[k]);
            check("c_err", rsp_err, c_err[k]);
            check("c_data", rsp_data, c_data[k]);
            step;
        end

        // Back-pressure in RESP with an LSU request pending
        ifu_rr = 0; ifu_v = 1; ifu_a = BASE + 16;
        wait_ready(0, ta);
        step; ifu_v = 0; lsu_v = 1; lsu_a = BASE + 4;
        wait_rsp(0, tr);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                step;
                @(negedge clk);
            end
            check("d_hold_valid", ifu_rsp_valid, 1);
            check("d_hold_data", rsp_data, 32'h1004_000C);
            check("d_hold_ifu_rdy", ifu_req_ready, 0);
            check("d_hold_lsu_rdy", lsu_req_ready, 0);
        end
        step; ifu_rr = 1;
        @(negedge clk);
        check("d_fire_valid", ifu_rsp_valid, 1);
        step;
        @(negedge clk);
        check("d_idle_next", lsu_req_ready, 1);
        ta = cyc;
        step; lsu_v = 0;
        wait_rsp(1, tr);
        check("d_lsu_latency", tr - ta, 2);
        check("d_lsu_data", rsp_data, 32'h1001_0003);
        step;

        // MEM_LAT=3 instance: abort by reset mid-WAIT, then a full transaction
        @(negedge clk);
        check("e_rst_maddr", maddr3, 0);
        step; rst3 = 0; ifu_v3 = 1; ifu_a3 = BASE + 8;
        @(negedge clk);
        check("e_accept", ifu_rdy3, 1);
        step; ifu_v3 = 0;
        @(negedge clk);
        check("e_maddr_t1", maddr3, BASE + 8);
        check("e_rv_t1", ifu_rv3, 0);
        step; rst3 = 1; lsu_v3 = 1; lsu_a3 = BASE + 4;
        @(negedge clk);
        check("e_rst_lsu_rdy", lsu_rdy3, 0);
        step; rst3 = 0;
        @(negedge clk);
        check("e_new_accept", lsu_rdy3, 1);
        t2 = cyc;
        step; lsu_v3 = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("e_offset", cyc - t2, k);
            check("e_maddr", maddr3, BASE + 4);
            check("e_lsu_rv", lsu_rv3, k == 4);
            check("e_ifu_rv", ifu_rv3, 0);
            if (k == 4) begin
                check("e_data", data3, 32'h1001_0003);
                check("e_err", err3, 0);
            end
            step;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("e_no_stale_rsp", ifu_rv3, 0);
            step;
        end

        repeat (3) step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
